// File: rtl/keypad_scanner_if.sv
// Key event bus between the keypad scanner and its consumer.
//   key_code   : last accepted key, row*4 + col
//   key_valid  : one-cycle pulse when key_code is updated (or auto-repeats)
//   key_down   : high while an accepted key is held
// master = scanner (producer), slave = consumer.
interface keypad_scanner_if;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;

  modport master (
    output key_code,
    output key_valid,
    output key_down
  );

  modport slave (
    input key_code,
    input key_valid,
    input key_down
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 keypad matrix scanner with debounce and single-key encoding.
// Drives one column low at a time, reads the active-low rows back through a
// 2-FF synchronizer, debounces one key and emits a one-cycle key event.
//
// Ports:
//   clk_50mhz : sole clock
//   rst_n     : asynchronous active-low reset
//   rows_i    : keypad rows, active-low, asynchronous to clk_50mhz
//   cols_o    : column drive, active-low, exactly one bit low
//   key_bus   : key event bus (key_code / key_valid / key_down), master side
//
// Optional feature: define KEYPAD_REPEAT_EN to auto-repeat key_valid while a key
// is held (first after REPEAT_DELAY samples, then every REPEAT_RATE samples).
module keypad_scanner #(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEBOUNCE_SCANS = 20,
  parameter int unsigned REPEAT_DELAY   = 500,
  parameter int unsigned REPEAT_RATE    = 100
) (
  input  logic                    clk_50mhz,
  input  logic                    rst_n,
  input  logic [3:0]              rows_i,
  output logic [3:0]              cols_o,
  keypad_scanner_if.master        key_bus
);

  localparam int unsigned SlotW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CntW  = $clog2(DEBOUNCE_SCANS + 1);

  typedef enum logic [1:0] {StScan, StDebounce, StHeld} state_e;

  state_e           state_q, state_d;
  logic [3:0]       rows_meta_q, rows_sync_q;
  logic [SlotW-1:0] slot_q;
  logic             sample;
  logic [1:0]       col_q, col_d;
  logic [1:0]       row_q, row_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [3:0]       code_q, code_d;
  logic             valid_q, valid_d;
  logic             any_low;
  logic [1:0]       low_idx;
  logic             row_low;

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RepW   = $clog2(RepMax + 1);

  logic [RepW-1:0] rep_q, rep_d;
  logic            fired_q, fired_d;
`endif

  // Rows are asynchronous; idle (released) level is high.
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      rows_meta_q <= 4'hF;
      rows_sync_q <= 4'hF;
    end else begin
      rows_meta_q <= rows_i;
      rows_sync_q <= rows_meta_q;
    end
  end

  // Free-running slot timer; the last cycle of a slot is the sample point.
  assign sample = (32'(slot_q) == SCAN_DIV - 1);

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else if (sample) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_q + 1'b1;
    end
  end

  // Lowest-index low row wins.
  always_comb begin
    any_low = ~&rows_sync_q;
    if (!rows_sync_q[0]) begin
      low_idx = 2'd0;
    end else if (!rows_sync_q[1]) begin
      low_idx = 2'd1;
    end else if (!rows_sync_q[2]) begin
      low_idx = 2'd2;
    end else begin
      low_idx = 2'd3;
    end
  end

  assign row_low = ~rows_sync_q[row_q];

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    valid_d = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_d   = rep_q;
    fired_d = fired_q;
    if (state_q != StHeld) begin
      rep_d   = '0;
      fired_d = 1'b0;
    end
`endif

    unique case (state_q)
      StScan: begin
        if (sample) begin
          if (any_low) begin
            row_d = low_idx;
            cnt_d = '0;
            // The capture sample already counts as the first match.
            if (DEBOUNCE_SCANS <= 1) begin
              code_d  = {low_idx, col_q};
              valid_d = 1'b1;
              state_d = StHeld;
            end else begin
              state_d = StDebounce;
            end
          end else begin
            col_d = col_q + 2'd1;
          end
        end
      end

      StDebounce: begin
        if (sample) begin
          if (row_low) begin
            // cnt_q counts matches after the capture sample.
            if (32'(cnt_q) + 32'd2 >= DEBOUNCE_SCANS) begin
              code_d  = {row_q, col_q};
              valid_d = 1'b1;
              cnt_d   = '0;
              state_d = StHeld;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            cnt_d   = '0;
            col_d   = col_q + 2'd1;
            state_d = StScan;
          end
        end
      end

      StHeld: begin
        if (sample) begin
          if (!row_low) begin
            if (32'(cnt_q) + 32'd1 >= DEBOUNCE_SCANS) begin
              cnt_d   = '0;
              col_d   = col_q + 2'd1;
              state_d = StScan;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
`ifdef KEYPAD_REPEAT_EN
            rep_d   = '0;
            fired_d = 1'b0;
`endif
          end else begin
            cnt_d = '0;
`ifdef KEYPAD_REPEAT_EN
            rep_d = rep_q + 1'b1;
            if ((!fired_q && (32'(rep_d) >= REPEAT_DELAY)) ||
                (fired_q && (32'(rep_d) >= REPEAT_RATE))) begin
              valid_d = 1'b1;
              rep_d   = '0;
              fired_d = 1'b1;
            end
`endif
          end
        end
      end

      default: begin
        state_d = StScan;
      end
    endcase
  end

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StScan;
      col_q   <= 2'd0;
      row_q   <= 2'd0;
      cnt_q   <= '0;
      code_q  <= 4'd0;
      valid_q <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_q   <= '0;
      fired_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      valid_q <= valid_d;
`ifdef KEYPAD_REPEAT_EN
      rep_q   <= rep_d;
      fired_q <= fired_d;
`endif
    end
  end

  assign cols_o            = ~(4'b0001 << col_q);
  assign key_bus.key_code  = code_q;
  assign key_bus.key_valid = valid_q;
  assign key_bus.key_down  = (state_q == StHeld);

endmodule
